uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel receive stage: oversamples the asynchronous `receive` line and recovers 8N1 frames, LSB first.
- Delivers each byte on a valid/ready handshake to the downstream transmit/echo path.
- Sits directly upstream of the UART transmitter; flags framing errors and overruns.
- Line idles high; default bit period is 18 clocks.

Parameters:
- CLKS_PER_BIT, 18, clocks per serial bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clock  input  1  system clock, rising-edge.
- clear  input  1  reset, asynchronous, active-low.
- receive  input  1  asynchronous serial line; idle high.
- data  output  DATA_BITS  received byte; stable while valid=1.
- valid  output  1  byte available.
- ready  input  1  consumer accepts byte; handshake completes on the clock where valid&&ready.
- framing_error  output  1  one-clock pulse: stop bit sampled low.
- overrun  output  1  sticky: a completed byte was dropped.

Behaviour:
- Reset (clear=0, async): state=IDLE; counters=0; synchronizer flops=1; data=0; valid=0; framing_error=0; overrun=0.
- Input sync: `receive` passes through 2 flops to form rx_s. All timing below is relative to rx_s.
- Bit counter is 0..DATA_BITS-1. Clock counter is 0..CLKS_PER_BIT-1.
- Sample point k (k=0 start, 1..DATA_BITS data, DATA_BITS+1 stop) falls at CLKS_PER_BIT/2 + k*CLKS_PER_BIT clocks after the first clock on which rx_s=0 in IDLE. For N=18: 9, 27, ..., 171.
- FSM:
  - IDLE: rx_s=0 -> START; clock counter cleared.
  - START: at sample 0, rx_s=0 -> DATA. rx_s=1 -> IDLE (glitch rejected, no outputs change).
  - DATA: at each sample, shift rx_s into the MSB of the shift register (LSB arrives first). After DATA_BITS samples -> STOP.
  - STOP: at the stop sample, rx_s=1 -> deliver byte, go to IDLE. rx_s=0 -> framing_error=1 for exactly one clock, byte discarded, go to BREAK.
  - BREAK: wait for rx_s=1, then -> IDLE. No re-arm while the line is held low.
- Delivery, registered on the clock after the stop sample:
  - valid=0, or valid=1 with ready=1 on that same clock: data<=shift register, valid=1. The simultaneous handshake consumes the old byte; no overrun.
  - valid=1 with ready=0: new byte dropped; data unchanged; overrun<=1.
- Handshake: valid&&ready at a rising edge -> valid<=0 next clock (unless a new delivery coincides, as above) and overrun<=0.
- data holds its value after the handshake; only a delivery changes it.
- Latency: valid rises 1 clock after the stop sample, i.e. 172 clocks after the rx_s falling edge for N=18 (~174 after the raw edge).
- A new frame is recognised in IDLE immediately after the stop sample. No mid-stop resync is required.
- Reset asserted mid-frame aborts the frame at once; all outputs return to reset values; no partial byte is ever presented.
- ready is ignored while valid=0.

Test Plan:
- 8N1 frames at 18 clocks/bit with ready=1, bits LSB-first 1,0,1,0,1,0,1,0 -> data=0x55, valid high exactly 1 clock, no error flags. Repeat for 0x00, 0xFF and 0x66 (bits 0,1,1,0,0,1,1,0).
- Latency check: raw falling edge of the start bit -> valid rises 174 ±1 clocks later; data stable from that edge.
- Glitch: receive low for 4 clocks then high -> FSM returns to IDLE, valid stays 0. A following real frame 0xA3 is received correctly.
- Framing: frame 0x3C with stop bit low, line held low 40 clocks -> framing_error pulses for 1 clock, valid=0, no frame detected until the line goes high. The next frame 0x81 is received correctly.
- Overrun: ready=0, send 0x12 then 0x34 back-to-back -> data=0x12, valid=1, overrun=1. Raise ready for 1 clock -> valid=0, overrun=0, data=0x12.
- Reset: assert clear low during data bit 4 of frame 0xF0 -> all outputs 0 asynchronously. After release, frame 0x0F -> data=0x0F.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive stage with oversampled bit recovery.
//
// The asynchronous `receive` line is synchronized through two flops and
// sampled in the middle of every bit. Recovered bytes are offered on a
// valid/ready handshake.
//
// Ports:
//   clock          system clock, rising-edge
//   clear          asynchronous active-low reset
//   receive        serial line, idles high
//   data           received byte, stable while valid=1
//   valid          byte available
//   ready          consumer accepts byte (handshake on valid && ready)
//   framing_error  one-clock pulse when the stop bit is sampled low
//   overrun        sticky; a completed byte was dropped while valid=1
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 18,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 receive,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_s;
    logic                   deliver;

    assign rx_s          = sync_q[1];
    assign data          = data_q;
    assign valid         = valid_q;
    assign overrun       = overrun_q;
    assign framing_error = frame_err_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], receive};
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CW'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                // Mid-start sample: a high line here was only a glitch.
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) state_d = StStop;
                    else bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            StStop: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold off re-arming until the line returns to idle.
                clk_cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // A handshake on the delivery clock frees the slot for the new byte.
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

endmodule
